// File: rtl/div_pkg.sv
// Shared constants and helpers for the constant-divisor multiple checker.
package div_pkg;

  localparam int unsigned MAX_DIVISOR = 255;

  // 2^i mod d by repeated doubling; only ever evaluated at elaboration.
  function automatic int unsigned residue_weight(input int unsigned i, input int unsigned d);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < i; k++) begin
      r = r << 1;
      if (r >= d) r = r - d;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_mod_reduce.sv
// Combinational reduction of a weighted bit sum modulo a constant divisor.
module div_mod_reduce #(
  parameter int unsigned DIVISOR = 3,
  parameter int unsigned ACC_W   = 5,
  parameter int unsigned RES_W   = 2
) (
  input  logic [ACC_W-1:0] sum,
  output logic [RES_W-1:0] residue
);

  localparam int unsigned WIDE_W = ACC_W + 8;

  logic [WIDE_W-1:0] rem;

  // Restoring division against constant DIVISOR<<k, largest shift first;
  // only the compare/subtract chain remains after constant folding.
  always_comb begin
    rem = WIDE_W'(sum);
    for (int unsigned k = ACC_W; k > 0; k--) begin
      if (rem >= (WIDE_W'(DIVISOR) << (k - 1))) begin
        rem = rem - (WIDE_W'(DIVISOR) << (k - 1));
      end
    end
    residue = rem[RES_W-1:0];
  end

endmodule

// File: rtl/div_checker.sv
// Registered check of whether an unsigned word is a multiple of a constant divisor.
module div_checker
  import div_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned DIVISOR = 3,
  localparam int unsigned RES_W   = $clog2(DIVISOR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  output logic              divisibility,
  output logic [RES_W-1:0]  residue
);

  localparam int unsigned ACC_W = $clog2(DATA_W * (DIVISOR - 1) + 1);

  if (DIVISOR < 2 || DIVISOR > MAX_DIVISOR) begin : g_bad_divisor
    $error("div_checker: DIVISOR out of range 2..255");
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("div_checker: DATA_W out of range 1..64");
  end

  logic [DATA_W-1:0] data_gated;
  logic [ACC_W-1:0]  term [DATA_W];
  logic [ACC_W-1:0]  weight_sum;
  logic [RES_W-1:0]  residue_next;

  logic              out_valid_d, out_valid_q;
  logic              divisible_d, divisible_q;
  logic [RES_W-1:0]  residue_d,   residue_q;

  // Idle-cycle data is forced to zero so unknowns never reach the adder tree.
  assign data_gated = in_valid ? data : '0;

  for (genvar g = 0; g < DATA_W; g++) begin : g_weight
    localparam int unsigned WEIGHT = residue_weight(g, DIVISOR);
    assign term[g] = data_gated[g] ? ACC_W'(WEIGHT) : '0;
  end

  always_comb begin
    weight_sum = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      weight_sum = weight_sum + term[i];
    end
  end

  div_mod_reduce #(
    .DIVISOR (DIVISOR),
    .ACC_W   (ACC_W),
    .RES_W   (RES_W)
  ) u_reduce (
    .sum     (weight_sum),
    .residue (residue_next)
  );

  always_comb begin
    out_valid_d = in_valid;
    divisible_d = divisible_q;
    residue_d   = residue_q;
    if (in_valid) begin
      residue_d   = residue_next;
      divisible_d = (residue_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      divisible_q <= 1'b0;
      residue_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      divisible_q <= divisible_d;
      residue_q   <= residue_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign divisibility = divisible_q;
  assign residue      = residue_q;

endmodule

// File: tb/tb_div_checker.sv
// Directed bench for div_checker with divisors 3, 5 and 8 on an 8-bit word.
module tb_div_checker;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] data;

  logic       ov3, dv3;
  logic [1:0] rs3;
  logic       ov5, dv5;
  logic [2:0] rs5;
  logic       ov8, dv8;
  logic [2:0] rs8;

  int checks;
  int failures;

  div_checker #(.DATA_W(8), .DIVISOR(3)) u_div3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .data(data),
    .out_valid(ov3), .divisibility(dv3), .residue(rs3)
  );
  div_checker #(.DATA_W(8), .DIVISOR(5)) u_div5 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .data(data),
    .out_valid(ov5), .divisibility(dv5), .residue(rs5)
  );
  div_checker #(.DATA_W(8), .DIVISOR(8)) u_div8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .data(data),
    .out_valid(ov8), .divisibility(dv8), .residue(rs8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] vec_in  [10] = '{8'd0, 8'd1, 8'd3, 8'd8, 8'd11, 8'd15, 8'd171, 8'd255, 8'd115, 8'd222};
  logic       vec_div [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] vec_res [10] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
  logic [7:0] b2b_in  [3]  = '{8'd6, 8'd7, 8'd9};
  logic       b2b_div [3]  = '{1'b1, 1'b0, 1'b1};

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held two cycles with a live word on the input.
    reset    = 1'b1;
    in_valid = 1'b1;
    data     = 8'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", ov3, 1'b0);
      check("rst_div", dv3, 1'b0);
      check("rst_residue", rs3, 2'd0);
    end
    reset = 1'b0;
    step();
    check("post_rst_out_valid", ov3, 1'b1);
    check("post_rst_div", dv3, 1'b1);
    check("post_rst_residue", rs3, 2'd0);

    for (int i = 0; i < 10; i++) begin
      data = vec_in[i];
      step();
      check($sformatf("vec%0d_valid", i), ov3, 1'b1);
      check($sformatf("vec%0d_div", i), dv3, vec_div[i]);
      check($sformatf("vec%0d_res", i), rs3, vec_res[i]);
    end

    for (int i = 0; i < 3; i++) begin
      data = b2b_in[i];
      step();
      check($sformatf("b2b%0d_valid", i), ov3, 1'b1);
      check($sformatf("b2b%0d_div", i), dv3, b2b_div[i]);
    end

    // Idle cycles with unknown data must hold the last result.
    data = 8'd12;
    step();
    check("hold_src_div", dv3, 1'b1);
    check("hold_src_res", rs3, 2'd0);
    in_valid = 1'b0;
    data     = 'x;
    for (int i = 0; i < 2; i++) begin
      step();
      check("idle_valid", ov3, 1'b0);
      check("idle_div", dv3, 1'b1);
      check("idle_res", rs3, 2'd0);
      check("idle_div5", dv5, 1'b0);
      check("idle_res5", rs5, 3'd2);
    end

    // Reset arriving right after a captured word clears it.
    in_valid = 1'b1;
    data     = 8'd10;
    step();
    check("pre_mid_rst_res", rs3, 2'd1);
    check("pre_mid_rst_div", dv3, 1'b0);
    reset = 1'b1;
    step();
    check("mid_rst_valid", ov3, 1'b0);
    check("mid_rst_res", rs3, 2'd0);
    check("mid_rst_div", dv3, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check("after_rst_valid", ov3, 1'b0);
    check("after_rst_res", rs3, 2'd0);
    check("after_rst_div", dv3, 1'b0);

    // Exhaustive sweep across all three divisors.
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data = 8'(i);
      step();
      check($sformatf("sw3_res_%0d", i), rs3, 32'(i % 3));
      check($sformatf("sw3_div_%0d", i), dv3, 32'(i % 3 == 0));
      check($sformatf("sw5_res_%0d", i), rs5, 32'(i % 5));
      check($sformatf("sw5_div_%0d", i), dv5, 32'(i % 5 == 0));
      check($sformatf("sw8_res_%0d", i), rs8, 32'(i % 8));
      check($sformatf("sw8_div_%0d", i), dv8, 32'(i % 8 == 0));
      check($sformatf("sw_valid_%0d", i), {ov3, ov5, ov8}, 3'b111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
